mix_columns: RTL and testbench

Iterative AES MixColumns engine for the encrypt datapath, the forward counterpart of the decrypt-side inverse column mix. It accepts one 128-bit state on a valid/ready handshake and transforms one 32-bit column per cycle through a single shared column multiplier. It then presents the result on a valid/ready output handshake. It sits between the ShiftRows stage and the AddRoundKey stage of each encryption round.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/mix_single_column.sv | 28 ++
 rtl/mix_columns.sv | 135 +++++++++++++
 tb/tb_mix_columns.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state enum, byte/column types, GF(2^8) xtime.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] column_t;

  // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
  localparam byte_t AES_POLY = 8'h1B;

  // Multiply by 2 in GF(2^8) modulo 0x11B.
  function automatic byte_t xtime(input byte_t b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational forward MixColumns for one 32-bit column (row 0 in the MSB).
module mix_single_column
  import aes_pkg::*;
(
  input  column_t i_col,
  output column_t o_col
);

  byte_t w_a0, w_a1, w_a2, w_a3;
  byte_t w_x0, w_x1, w_x2, w_x3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3a = 2a ^ a, so each output row is a XOR of doubled and plain bytes.
  assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
  assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/mix_columns.sv
// Iterative AES MixColumns: one column per cycle through a shared multiplier.
// Optional feature macro: AES_MIX_BYPASS_EN (adds the bypass port, final round).
//
// state | meaning
// IDLE  | in_ready high, waiting for a state on in_valid
// BUSY  | columns 0..3 transformed one per cycle, then one cycle to publish
// DONE  | out_valid high, data_out held until out_ready
module mix_columns
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
`ifdef AES_MIX_BYPASS_EN
  input  logic         bypass,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_work;
  logic [127:0] r_data_out;
  logic [1:0]   r_col;
  logic         r_last;
  column_t      w_col_in;
  column_t      w_col_out;
  logic [127:0] w_work_upd;
  logic         w_skip;

`ifdef AES_MIX_BYPASS_EN
  logic r_bypass;
  assign w_skip = r_bypass;
`else
  assign w_skip = 1'b0;
`endif

  // Select the column currently being transformed.
  always_comb begin
    w_col_in = r_work[127:96];
    case (r_col)
      2'd0: w_col_in = r_work[127:96];
      2'd1: w_col_in = r_work[95:64];
      2'd2: w_col_in = r_work[63:32];
      2'd3: w_col_in = r_work[31:0];
      default: w_col_in = r_work[127:96];
    endcase
  end

  mix_single_column u_mix (
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  // Work register with the current column replaced by its transform.
  always_comb begin
    w_work_upd = r_work;
    case (r_col)
      2'd0: w_work_upd[127:96] = w_col_out;
      2'd1: w_work_upd[95:64]  = w_col_out;
      2'd2: w_work_upd[63:32]  = w_col_out;
      2'd3: w_work_upd[31:0]   = w_col_out;
      default: w_work_upd = r_work;
    endcase
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (r_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, column counter, work and result registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_work     <= '0;
      r_data_out <= '0;
      r_col      <= 2'd0;
      r_last     <= 1'b0;
`ifdef AES_MIX_BYPASS_EN
      r_bypass   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work   <= data_in;
            r_col    <= 2'd0;
            r_last   <= 1'b0;
`ifdef AES_MIX_BYPASS_EN
            r_bypass <= bypass;
`endif
          end
        end
        BUSY: begin
          if (r_last) begin
            // All four columns done: publish and wrap the counter.
            r_data_out <= r_work;
            r_col      <= 2'd0;
            r_last     <= 1'b0;
          end else begin
            if (!w_skip) r_work <= w_work_upd;
            if (r_col == 2'd3) r_last <= 1'b1;
            else               r_col  <= r_col + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_mix_columns.sv
// Scoreboard bench for mix_columns with a matrix-form GF(2^8) reference model.
module tb_mix_columns;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
`ifdef AES_MIX_BYPASS_EN
  logic         bypass;
`endif

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam int LAT_EDGES = 5;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   lat_done = 1'b0;

  mix_columns dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
`ifdef AES_MIX_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok,
                       input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Generic shift-and-add GF(2^8) multiply modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] acc;
    logic [8:0] aa;
    acc = 9'd0;
    aa  = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11B;
    end
    return acc[7:0];
  endfunction

  // Column vector times the circulant matrix with first row {2,3,1,1}.
  function automatic logic [127:0] mix_ref(input logic [127:0] d);
    logic [7:0] coeff [4];
    logic [7:0] a [4];
    logic [7:0] b;
    logic [127:0] res;
    coeff[0] = 8'd2; coeff[1] = 8'd3; coeff[2] = 8'd1; coeff[3] = 8'd1;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = 8'((d >> (120 - 32*c - 8*r)) & 128'hff);
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coeff[(k - r + 4) % 4], a[k]);
        res = res | (128'(b) << (120 - 32*c - 8*r));
      end
    end
    return res;
  endfunction

  // Scoreboard: observe outputs, then account for the handshakes of the coming edge.
  always begin
    @(negedge clk);
    #1;
    if (n_rst && out_valid) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 1'b0, data_out, 128'h0);
      end else begin
        check("data_out", data_out === q[0].data, data_out, q[0].data);
        check("in_ready_low_in_done", in_ready === 1'b0, 128'(in_ready), 128'h0);
        if (!lat_done) begin
          lat_done = 1'b1;
          check("latency", (cyc - q[0].acc) == LAT_EDGES + 1,
                128'(cyc - q[0].acc), 128'(LAT_EDGES + 1));
        end
      end
    end
    if (!n_rst) begin
      q.delete();
      lat_done = 1'b0;
    end else begin
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        lat_done = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = mix_ref(data_in);
`ifdef AES_MIX_BYPASS_EN
        if (bypass) e.data = data_in;
`endif
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [127:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", in_ready === 1'b1, 128'(n), 128'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [127:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!out_valid && n < 30);
    check(name, out_valid === 1'b1 && data_out === exp, data_out, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int n;
    logic [127:0] d;
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
`ifdef AES_MIX_BYPASS_EN
    bypass    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #2;
    check("rst_out_valid", out_valid === 1'b0, 128'(out_valid), 128'h0);
    check("rst_in_ready", in_ready === 1'b1, 128'(in_ready), 128'h1);
    check("rst_data_out", data_out === 128'h0, data_out, 128'h0);
    n_rst = 1'b1;

    // Known-answer vectors.
    send(V1_IN);
    wait_valid("vector1", V1_OUT);
    send(V2_IN);
    wait_valid("vector2", V2_OUT);

    // Backpressure in DONE with stray in_valid pulses.
    @(negedge clk);
    out_ready = 1'b0;
    send(V1_IN);
    wait_valid("bp_first", V1_OUT);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      data_in  = 128'(i) ^ V2_IN;
      #2;
      check("bp_out_valid", out_valid === 1'b1, 128'(out_valid), 128'h1);
      check("bp_hold", data_out === V1_OUT, data_out, V1_OUT);
      check("bp_in_ready", in_ready === 1'b0, 128'(in_ready), 128'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    #2;
    check("bp_release_in_ready", in_ready === 1'b1, 128'(in_ready), 128'h1);
    check("bp_release_out_valid", out_valid === 1'b0, 128'(out_valid), 128'h0);

    // Reset on the second BUSY cycle abandons the block.
    send(V2_IN);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    #2;
    check("midrst_out_valid", out_valid === 1'b0, 128'(out_valid), 128'h0);
    check("midrst_data_out", data_out === 128'h0, data_out, 128'h0);
    check("midrst_in_ready", in_ready === 1'b1, 128'(in_ready), 128'h1);
    n_rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #2;
      check("midrst_no_output", out_valid === 1'b0, 128'(out_valid), 128'h0);
    end
    send(V2_IN);
    wait_valid("after_rst", V2_OUT);

`ifdef AES_MIX_BYPASS_EN
    bypass = 1'b1;
    send(V1_IN);
    wait_valid("bypass_on", V1_IN);
    bypass = 1'b0;
    send(V1_IN);
    wait_valid("bypass_off", V1_OUT);
`endif

    // Back-to-back random stream with random out_ready.
    @(negedge clk);
    sent = 0;
    n    = 0;
    while (sent < 8 && n < 2000) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      do begin
        @(negedge clk);
        in_valid  = 1'b1;
        data_in   = d;
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end while (!in_ready && n < 2000);
      if (in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    out_ready = 1'b1;
    check("stream_sent", sent == 8, 128'(sent), 128'd8);
    repeat (3) @(negedge clk);
    check("stream_drained", q.size() == 0, 128'(q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
